sram_2p_march_bist_ctrl: RTL and testbench

// - March C- BIST engine for one port of the RM_IHPSG13_2P_512x16_c2_bm_bist dual-port SRAM macro.
// - Drives the port's *_BIST_* inputs, and checks the port's DOUT against expected data.
// - One instance is placed per port, directly upstream of the macro.
// - Reports pass/fail, the first failing address and a saturating error count to the test controller.

---
 rtl/sram_2p_march_bist_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_2p_march_bist_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2p_march_bist_ctrl.sv
//------------------------------------------------------------------------------
// Module  : sram_2p_march_bist_ctrl
// Brief   : March C- BIST engine for one port of a 2-port 512x16 SRAM macro.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sram_2p_march_bist_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 9,
    parameter int DEPTH = 512
) (
    input  logic          BIST_CLK,
    input  logic          BIST_RST_N,
    input  logic          START,
    output logic          BIST_EN,
    output logic          BIST_MEN,
    output logic          BIST_WEN,
    output logic          BIST_REN,
    output logic [AW-1:0] BIST_ADDR,
    output logic [DW-1:0] BIST_DIN,
    output logic [DW-1:0] BIST_BM,
    input  logic [DW-1:0] BIST_DOUT,
    output logic          BUSY,
    output logic          DONE,
    output logic          FAIL,
    output logic [AW-1:0] FAIL_ADDR,
    output logic [7:0]    ERR_CNT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [2:0]    E_LAST    = 3'd5;

    // Element 0 is w0, 1..4 are read/write pairs, 5 is the closing r0.
    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic is_pair(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic is_write(input logic [2:0] e, input logic rd);
        return (e == 3'd0) || (is_pair(e) && !rd);
    endfunction

    // Data polarity of an op: read expectation or write pattern.
    function automatic logic data_one(input logic [2:0] e, input logic rd);
        return rd ? ((e == 3'd2) || (e == 3'd4)) : ((e == 3'd1) || (e == 3'd3));
    endfunction

    state_e        state_q, state_d;
    logic [2:0]    elem_q, elem_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          men_q, men_d;
    logic          wen_q, wen_d;
    logic          ren_q, ren_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] bm_q, bm_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          cmp_vld_q, cmp_vld_d;
    logic          cmp_exp_q, cmp_exp_d;
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;

    logic [2:0]    nxt_elem;
    logic [AW-1:0] nxt_addr;
    logic          nxt_rd;
    logic          last_op;
    logic          at_end;
    logic          nxt_wr;

    always_comb begin
        nxt_elem = elem_q;
        nxt_addr = addr_q;
        nxt_rd   = rd_q;
        last_op  = 1'b0;
        at_end   = is_down(elem_q) ? (addr_q == '0) : (addr_q == LAST_ADDR);
        if (is_pair(elem_q) && rd_q) begin
            nxt_rd = 1'b0;
        end else if (at_end) begin
            if (elem_q == E_LAST) begin
                last_op = 1'b1;
            end else begin
                nxt_elem = elem_q + 3'd1;
                nxt_addr = is_down(elem_q + 3'd1) ? LAST_ADDR : '0;
                nxt_rd   = 1'b1;
            end
        end else begin
            nxt_addr = is_down(elem_q) ? (addr_q - AW'(1)) : (addr_q + AW'(1));
            nxt_rd   = (elem_q != 3'd0);
        end
        nxt_wr = is_write(nxt_elem, nxt_rd);
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        men_d       = 1'b0;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        din_d       = din_q;
        bm_d        = '0;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        err_cnt_d   = err_cnt_q;
        // The read sampled at this edge is checked one edge later.
        cmp_vld_d   = men_q && ren_q;
        cmp_exp_d   = data_one(elem_q, rd_q);
        cmp_addr_d  = addr_q;

        if (cmp_vld_q && (BIST_DOUT != {DW{cmp_exp_q}})) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
            end
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d     = S_RUN;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    err_cnt_d   = '0;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    rd_d        = 1'b0;
                    men_d       = 1'b1;
                    wen_d       = 1'b1;
                    din_d       = '0;
                    bm_d        = '1;
                end
            end
            S_RUN: begin
                if (last_op) begin
                    state_d = S_FLUSH;
                end else begin
                    elem_d = nxt_elem;
                    addr_d = nxt_addr;
                    rd_d   = nxt_rd;
                    men_d  = 1'b1;
                    wen_d  = nxt_wr;
                    ren_d  = !nxt_wr;
                    din_d  = {DW{nxt_wr && data_one(nxt_elem, nxt_rd)}};
                    bm_d   = {DW{nxt_wr}};
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge BIST_CLK or negedge BIST_RST_N) begin
        if (!BIST_RST_N) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            din_q       <= '0;
            bm_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            err_cnt_q   <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= 1'b0;
            cmp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            men_q       <= men_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            din_q       <= din_d;
            bm_q        <= bm_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            err_cnt_q   <= err_cnt_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    assign BIST_EN   = busy_q;
    assign BIST_MEN  = men_q;
    assign BIST_WEN  = wen_q;
    assign BIST_REN  = ren_q;
    assign BIST_ADDR = addr_q;
    assign BIST_DIN  = din_q;
    assign BIST_BM   = bm_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign FAIL      = fail_q;
    assign FAIL_ADDR = fail_addr_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_2p_march_bist_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_sram_2p_march_bist_ctrl
// Brief   : Directed bench for the March C- BIST controller with behavioural SRAMs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_2p_march_bist_ctrl;

    localparam int DW = 16;
    localparam int AW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start4;

    logic          en, men, wen, ren, busy, done, fail;
    logic [AW-1:0] addr, fail_addr;
    logic [DW-1:0] din, bm, dout;
    logic [7:0]    err_cnt;

    logic          en4, men4, wen4, ren4, busy4, done4, fail4;
    logic [AW-1:0] addr4, fail_addr4;
    logic [DW-1:0] din4, bm4, dout4;
    logic [7:0]    err_cnt4;

    sram_2p_march_bist_ctrl #(.DW(DW), .AW(AW), .DEPTH(512)) dut (
        .BIST_CLK(clk), .BIST_RST_N(rst_n), .START(start),
        .BIST_EN(en), .BIST_MEN(men), .BIST_WEN(wen), .BIST_REN(ren),
        .BIST_ADDR(addr), .BIST_DIN(din), .BIST_BM(bm), .BIST_DOUT(dout),
        .BUSY(busy), .DONE(done), .FAIL(fail), .FAIL_ADDR(fail_addr), .ERR_CNT(err_cnt)
    );

    sram_2p_march_bist_ctrl #(.DW(DW), .AW(AW), .DEPTH(4)) dut4 (
        .BIST_CLK(clk), .BIST_RST_N(rst_n), .START(start4),
        .BIST_EN(en4), .BIST_MEN(men4), .BIST_WEN(wen4), .BIST_REN(ren4),
        .BIST_ADDR(addr4), .BIST_DIN(din4), .BIST_BM(bm4), .BIST_DOUT(dout4),
        .BUSY(busy4), .DONE(done4), .FAIL(fail4), .FAIL_ADDR(fail_addr4), .ERR_CNT(err_cnt4)
    );

    // Behavioural SRAMs; fault_mode 1 = bit 5 of 0x0A3 stuck at 1, 2 = reads return 0xFFFF.
    logic [DW-1:0] mem  [512];
    logic [DW-1:0] mem4 [4];
    int fault_mode = 0;

    always @(posedge clk) begin
        if (men && wen) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
        else if (men && ren) begin
            case (fault_mode)
                1:       dout <= mem[addr] | ((addr == 9'h0A3) ? 16'h0020 : 16'h0000);
                2:       dout <= 16'hFFFF;
                default: dout <= mem[addr];
            endcase
        end
        if (men4 && wen4) mem4[addr4[1:0]] <= (mem4[addr4[1:0]] & ~bm4) | (din4 & bm4);
        else if (men4 && ren4) dout4 <= mem4[addr4[1:0]];
    end

    int wr_ops = 0, rd_ops = 0, proto_err = 0;
    logic [26:0] trace_q [$];

    always @(posedge clk) begin
        if (men && wen) wr_ops++;
        if (men && ren) rd_ops++;
        if (men && (wen == ren)) proto_err++;
        if (!men && (wen || ren)) proto_err++;
        if (bm !== {DW{wen}}) proto_err++;
        if (men4) trace_q.push_back({wen4, ren4, addr4, din4});
    end

    int n_pass = 0, n_total = 0;

    task automatic start_run(input bit sel);
        @(negedge clk);
        if (sel) start4 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    // Counts edges after edge 0 until DONE is seen; optionally pulses START mid-run.
    task automatic wait_done(input bit sel, input int pulse_at, output int edge_n, output bit prev_busy);
        edge_n    = 0;
        prev_busy = 1'b0;
        while (edge_n < 6000) begin
            prev_busy = busy;
            @(posedge clk);
            edge_n++;
            #1;
            start = (edge_n == pulse_at);
            if (sel ? done4 : done) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({en, men, wen, ren, addr, din, bm, busy, done, fail, fail_addr, err_cnt} !== '0)
            $display("FAIL reset_outputs: got en=%b men=%b busy=%b done=%b fail=%b err=%0d, want all 0",
                     en, men, busy, done, fail, err_cnt);
        else n_pass++;
        n_total++;
        if ({en4, men4, busy4, done4, fail4, err_cnt4} !== '0)
            $display("FAIL reset_outputs4: got en=%b men=%b busy=%b done=%b, want 0", en4, men4, busy4, done4);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_clean_run();
        int e, w0, r0;
        bit pb;
        fault_mode = 0;
        w0 = wr_ops; r0 = rd_ops;
        start_run(1'b0);
        n_total++;
        if (busy !== 1'b1 || en !== 1'b1) $display("FAIL clean_busy_rise: busy=%b en=%b, want 1 1", busy, en);
        else n_pass++;
        wait_done(1'b0, -1, e, pb);
        n_total++;
        if (e !== 5121) $display("FAIL clean_done_edge: got %0d, want 5121", e); else n_pass++;
        n_total++;
        if (busy !== 1'b0 || pb !== 1'b1 || en !== 1'b0)
            $display("FAIL clean_busy_fall: busy=%b prev=%b en=%b, want 0 1 0", busy, pb, en);
        else n_pass++;
        n_total++;
        if (fail !== 1'b0 || err_cnt !== 8'd0) $display("FAIL clean_result: fail=%b err=%0d, want 0 0", fail, err_cnt);
        else n_pass++;
        n_total++;
        if (wr_ops - w0 !== 2560 || rd_ops - r0 !== 2560)
            $display("FAIL clean_op_count: writes=%0d reads=%0d, want 2560 2560", wr_ops - w0, rd_ops - r0);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (men !== 1'b0 || done !== 1'b1) $display("FAIL clean_done_idle: men=%b done=%b, want 0 1", men, done);
        else n_pass++;
    endtask

    task automatic test_trace_depth4();
        logic [26:0] exp_q [$];
        logic [26:0] mask;
        int e, base, bad;
        bit pb;
        for (int a = 0; a < 4; a++) exp_q.push_back({2'b10, 9'(a), 16'h0000});
        for (int a = 0; a < 4; a++) begin exp_q.push_back({2'b01, 9'(a), 16'h0}); exp_q.push_back({2'b10, 9'(a), 16'hFFFF}); end
        for (int a = 0; a < 4; a++) begin exp_q.push_back({2'b01, 9'(a), 16'h0}); exp_q.push_back({2'b10, 9'(a), 16'h0000}); end
        for (int a = 3; a >= 0; a--) begin exp_q.push_back({2'b01, 9'(a), 16'h0}); exp_q.push_back({2'b10, 9'(a), 16'hFFFF}); end
        for (int a = 3; a >= 0; a--) begin exp_q.push_back({2'b01, 9'(a), 16'h0}); exp_q.push_back({2'b10, 9'(a), 16'h0000}); end
        for (int a = 0; a < 4; a++) exp_q.push_back({2'b01, 9'(a), 16'h0});
        base = trace_q.size();
        start_run(1'b1);
        wait_done(1'b1, -1, e, pb);
        n_total++;
        if (e !== 41) $display("FAIL d4_done_edge: got %0d, want 41", e); else n_pass++;
        n_total++;
        if (trace_q.size() - base !== 40) $display("FAIL d4_op_count: got %0d, want 40", trace_q.size() - base);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 40 && base + i < trace_q.size(); i++) begin
            mask = exp_q[i][26] ? 27'h7FF_FFFF : 27'h7FF_0000;
            if ((trace_q[base + i] & mask) !== (exp_q[i] & mask)) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL d4_trace: %0d ops differ, want 0", bad); else n_pass++;
        n_total++;
        if (fail4 !== 1'b0 || err_cnt4 !== 8'd0) $display("FAIL d4_result: fail=%b err=%0d, want 0 0", fail4, err_cnt4);
        else n_pass++;
    endtask

    task automatic test_stuck_bit();
        int e;
        bit pb;
        fault_mode = 1;
        start_run(1'b0);
        wait_done(1'b0, 2000, e, pb);
        n_total++;
        if (e !== 5121) $display("FAIL stuck_done_edge: got %0d, want 5121 (mid-run START ignored)", e); else n_pass++;
        n_total++;
        if (fail !== 1'b1 || fail_addr !== 9'h0A3 || err_cnt !== 8'd3)
            $display("FAIL stuck_result: fail=%b addr=%h err=%0d, want 1 0a3 3", fail, fail_addr, err_cnt);
        else n_pass++;
    endtask

    task automatic test_restart_clears();
        int e;
        bit pb;
        fault_mode = 0;
        start_run(1'b0);
        n_total++;
        if (fail !== 1'b0 || fail_addr !== '0 || err_cnt !== 8'd0 || done !== 1'b0 || busy !== 1'b1)
            $display("FAIL restart_clear: fail=%b addr=%h err=%0d done=%b busy=%b, want 0 000 0 0 1",
                     fail, fail_addr, err_cnt, done, busy);
        else n_pass++;
        wait_done(1'b0, -1, e, pb);
        n_total++;
        if (e !== 5121 || fail !== 1'b0) $display("FAIL restart_rerun: edge=%0d fail=%b, want 5121 0", e, fail);
        else n_pass++;
    endtask

    task automatic test_all_ones();
        int e;
        bit pb;
        fault_mode = 2;
        start_run(1'b0);
        wait_done(1'b0, -1, e, pb);
        n_total++;
        if (e !== 5121) $display("FAIL ones_done_edge: got %0d, want 5121", e); else n_pass++;
        n_total++;
        if (fail !== 1'b1 || fail_addr !== 9'h000 || err_cnt !== 8'd255)
            $display("FAIL ones_result: fail=%b addr=%h err=%0d, want 1 000 255", fail, fail_addr, err_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int e;
        bit pb;
        fault_mode = 0;
        start_run(1'b0);
        repeat (1000) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({en, men, wen, ren, addr, din, bm, busy, done, fail, fail_addr, err_cnt} !== '0)
            $display("FAIL midrun_reset_outputs: en=%b men=%b addr=%h busy=%b, want all 0", en, men, addr, busy);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0 || men !== 1'b0 || done !== 1'b0)
            $display("FAIL midrun_no_resume: busy=%b men=%b done=%b, want 0 0 0", busy, men, done);
        else n_pass++;
        start_run(1'b0);
        wait_done(1'b0, -1, e, pb);
        n_total++;
        if (e !== 5121 || fail !== 1'b0 || err_cnt !== 8'd0)
            $display("FAIL midrun_rerun: edge=%0d fail=%b err=%0d, want 5121 0 0", e, fail, err_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_trace_depth4();
        test_stuck_bit();
        test_restart_clears();
        test_all_ones();
        test_reset_midrun();
        n_total++;
        if (proto_err !== 0) $display("FAIL op_protocol: %0d bad cycles, want 0", proto_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
